uart_echo_responder: RTL and testbench
======================================

// Module: uart_echo_responder
// PURPOSE
//  Far-end UART device: deserialises frames (start, LSB-first data, even parity, stop) from rx_in.
//  Checks parity and stop bit, buffers good bytes in a small FIFO, and re-serialises them on tx_out.
//  Provides the remote peer for the tx/rx/baud-gen loopback top, so a link can be exercised end to end.
//  Single clock domain; all bit timing comes from a 16x-oversampling tick enable supplied by the baud generator.
// PARAMETERS
//  DATA_BITS   8   data bits per frame
//  OVS         16  tick_16x pulses per bit period
//  FIFO_DEPTH  4   echo FIFO entries (power of 2)
// PORTS
//  clk         in   1          system clock
//  rst         in   1          async reset, active-low
//  tick_16x    in   1          1-clk enable pulse, OVS per bit
//  rx_in       in   1          serial input, idle high
//  echo_en     in   1          1 = FIFO drains to tx_out; 0 = bytes held
//  tx_out      out  1          serial output, idle high
//  rx_data     out  DATA_BITS  last good received byte
//  rx_valid    out  1          1-clk pulse when rx_data updates
//  parity_err  out  1          1-clk pulse, parity mismatch on the frame just ended
//  stop_err    out  1          1-clk pulse, stop bit sampled low
//  overrun     out  1          1-clk pulse, good byte dropped because FIFO full
//  fifo_full   out  1          FIFO occupancy == FIFO_DEPTH
//  tx_busy     out  1          TX FSM not IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - tx_out=1; rx_data=0; all pulses/flags=0; FIFO empty; both FSMs IDLE; counters cleared.
//  RX input: rx_in passes through a 2-FF synchroniser before any use.
//  RX FSM (advances only on tick_16x): IDLE->START->DATA->PARITY->STOP->IDLE.
//   - IDLE: synchronised rx_in low on a tick -> START, tick count=0.
//   - START: re-sample at count OVS/2-1. Low -> DATA. High -> IDLE (glitch reject, no error).
//   - DATA/PARITY/STOP: sample every OVS ticks (mid-bit). DATA shifts LSB first, DATA_BITS samples.
//   - Parity: even (XOR of data bits and parity bit must be 0).
//   - STOP sample: pulses fire the following clk.
//     - Parity bad -> parity_err. Stop low -> stop_err. Both may pulse together.
//     - Any error -> byte discarded: no rx_valid, no push.
//     - Good and FIFO not full -> rx_data updated, rx_valid, push.
//     - Good and FIFO full -> rx_data updated, rx_valid, overrun; byte not pushed.
//   - RX returns to IDLE right after the stop sample; back-to-back frames are accepted.
//  FIFO: circular buffer, log2(FIFO_DEPTH)+1-bit pointers.
//   - Full when MSBs differ and the rest are equal; empty when the pointers are equal.
//   - Push and pop in the same clk: both act, occupancy unchanged; allowed when full (pop frees slot first).
//  TX FSM: IDLE->START->DATA->PARITY->STOP->IDLE. Each bit is held for OVS ticks.
//   - IDLE: echo_en=1 and FIFO not empty -> pop into shift reg; tx_out=0 (start) from next tick, tx_busy=1.
//   - Sends DATA_BITS LSB first, then even parity bit, then stop=1.
//   - Leaves STOP after OVS ticks; may start the next byte on the following tick (no extra idle bit).
//   - echo_en deasserted mid-frame: current frame completes; no new pop.
//  Reset mid-frame: both FSMs abort immediately, tx_out=1, FIFO contents lost.
//  tick_16x never high two clks in a row; FSMs hold state between ticks.
// TESTING
//  1. Reset with rx_in=1 -> tx_out=1, all outputs 0, tx_busy=0.
//  2. Send 0xA5 (data 1,0,1,0,0,1,0,1, parity 0, stop 1), echo_en=1:
//     -> rx_valid once, rx_data=0xA5, then tx_out replays the identical 11-bit frame, tx_busy across it.
//  3. Send 0x07 with parity bit 0 (should be 1) -> parity_err pulse, no rx_valid, tx_out stays 1.
//  4. Send 0x3C with stop bit 0 -> stop_err pulse, byte discarded; next good 0x55 frame is received and echoed.
//  5. echo_en=0, send 5 good bytes 0x01..0x05 -> fifo_full after 4th, overrun on 5th.
//     Then echo_en=1 -> echoes 01,02,03,04 in order.
//  6. 1/4-bit low glitch on idle rx_in -> no pulses. Then assert rst mid-TX -> tx_out=1 at once, FIFO empty.

Source files
------------

// File: rtl/uart_echo_responder.sv
// Far-end UART echo device: receives even-parity frames on rx_in, buffers good bytes
// in a small FIFO and replays them on tx_out, all timed by a 16x oversampling tick.
`timescale 1ns/1ps

module uart_echo_responder #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_16x,
    input  logic                 rx_in,
    input  logic                 echo_en,
    output logic                 tx_out,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 stop_err,
    output logic                 overrun,
    output logic                 fifo_full,
    output logic                 tx_busy
);

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic                 rx_meta_q, rx_sync_q;
    state_e               rx_state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, parity_err_q, stop_err_q, overrun_q;

    state_e               tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 tx_out_q, tx_busy_q;

    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic                 fifo_empty, fifo_is_full, fifo_push, fifo_pop;
    logic [DATA_BITS-1:0] pop_data;
    logic                 rx_stop_sample, rx_good;

    // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_is_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data     = fifo_mem[rd_ptr_q[AW-1:0]];

    assign rx_stop_sample = tick_16x && (rx_state_q == S_STOP) && (rx_cnt_q == CNT_LAST);
    assign rx_good        = !(^{rx_shift_q, rx_par_q}) && rx_sync_q;
    assign fifo_pop       = tick_16x && (tx_state_q == S_IDLE) && echo_en && !fifo_empty;
    // A pop in the same clk frees the slot, so a full FIFO can still accept the byte.
    assign fifo_push      = rx_stop_sample && rx_good && (!fifo_is_full || fifo_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
            if (tick_16x) begin
                case (rx_state_q)
                    S_IDLE: begin
                        if (!rx_sync_q) begin
                            rx_state_q <= S_START;
                            rx_cnt_q   <= '0;
                        end
                    end
                    S_START: begin
                        if (rx_cnt_q == CNT_HALF) begin
                            rx_cnt_q   <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (rx_cnt_q == CNT_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                            rx_bit_q   <= rx_bit_q + 1'b1;
                            if (rx_bit_q == BIT_LAST) rx_state_q <= S_PARITY;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (rx_cnt_q == CNT_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_par_q   <= rx_sync_q;
                            rx_state_q <= S_STOP;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (rx_cnt_q == CNT_LAST) begin
                            rx_cnt_q     <= '0;
                            rx_state_q   <= S_IDLE;
                            parity_err_q <= ^{rx_shift_q, rx_par_q};
                            stop_err_q   <= !rx_sync_q;
                            if (rx_good) begin
                                rx_data_q  <= rx_shift_q;
                                rx_valid_q <= 1'b1;
                                overrun_q  <= !fifo_push;
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                    default: rx_state_q <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else if (tick_16x) begin
            case (tx_state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        tx_shift_q <= pop_data;
                        tx_par_q   <= ^pop_data;
                        tx_out_q   <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_out_q   <= tx_shift_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == BIT_LAST) begin
                            tx_out_q   <= tx_par_q;
                            tx_state_q <= S_PARITY;
                        end else begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_out_q   <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_out_q   <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_out     = tx_out_q;
    assign tx_busy    = tx_busy_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign stop_err   = stop_err_q;
    assign overrun    = overrun_q;
    assign fifo_full  = fifo_is_full;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Self-checking bench for uart_echo_responder: directed frames plus random frames,
// compared against a byte-level model of expected pulses and echoed bytes.
`timescale 1ns/1ps

module tb_uart_echo_responder;

    localparam int DATA_BITS  = 8;
    localparam int OVS        = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 4;
    localparam int BIT_CLKS   = OVS * DIV;
    localparam int DRAIN_MAX  = 30000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_16x;
    logic       rx_in;
    logic       echo_en;
    logic       tx_out;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, stop_err, overrun, fifo_full, tx_busy;

    uart_echo_responder #(
        .DATA_BITS (DATA_BITS),
        .OVS       (OVS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_16x  (tick_16x),
        .rx_in     (rx_in),
        .echo_en   (echo_en),
        .tx_out    (tx_out),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .stop_err  (stop_err),
        .overrun   (overrun),
        .fifo_full (fifo_full),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: byte-level expectations derived from the frame contents.
    logic [7:0] exp_q[$];
    int         exp_valid = 0, exp_par = 0, exp_stop = 0, exp_ovr = 0, held = 0;
    logic [7:0] exp_last = 8'h00;

    int         obs_valid = 0, obs_par = 0, obs_stop = 0, obs_ovr = 0, tx_low_cnt = 0;
    logic [7:0] obs_last = 8'h00;
    bit         mon_abort = 1'b0;

    initial begin
        tick_16x = 1'b0;
        forever begin
            repeat (DIV - 1) @(posedge clk);
            #1 tick_16x = 1'b1;
            @(posedge clk);
            #1 tick_16x = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rx_valid === 1'b1) begin
                obs_valid++;
                obs_last = rx_data;
            end
            if (parity_err === 1'b1) obs_par++;
            if (stop_err === 1'b1)   obs_stop++;
            if (overrun === 1'b1)    obs_ovr++;
            if (tx_out === 1'b0)     tx_low_cnt++;
        end
    end

    // Decodes frames on tx_out by mid-bit sampling and matches them to the model queue.
    initial begin
        logic [10:0] f;
        logic [7:0]  e;
        bit          busy_ok;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_out === 1'b0) begin
                repeat (BIT_CLKS / 2 - 1) @(negedge clk);
                f[0]    = tx_out;
                busy_ok = (tx_busy === 1'b1);
                for (int i = 1; i < 11; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    f[i] = tx_out;
                    if (tx_busy !== 1'b1) busy_ok = 1'b0;
                end
                if (!mon_abort) begin
                    check("tx_expected_frame", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tx_start", f[0], 0);
                        check("tx_data", f[8:1], e);
                        check("tx_parity", f[9], ^e);
                        check("tx_stop", f[10], 1);
                        check("tx_busy_during_frame", busy_ok, 1);
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
        if (bad_stop) begin
            repeat (2 * BIT_CLKS) @(posedge clk);
            #1;
        end
        if (bad_par)  exp_par++;
        if (bad_stop) exp_stop++;
        if (!bad_par && !bad_stop) begin
            exp_valid++;
            exp_last = d;
            if (!echo_en && held == FIFO_DEPTH) begin
                exp_ovr++;
            end else begin
                exp_q.push_back(d);
                if (!echo_en) held++;
            end
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rx_valid_count"}, obs_valid, exp_valid);
        check({tag, "_parity_err_count"}, obs_par, exp_par);
        check({tag, "_stop_err_count"}, obs_stop, exp_stop);
        check({tag, "_overrun_count"}, obs_ovr, exp_ovr);
        check({tag, "_rx_data"}, obs_last, exp_last);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_echo_queue_left"}, exp_q.size(), 0);
        check({tag, "_tx_busy_idle"}, tx_busy, 0);
    endtask

    initial begin
        int         low_before;
        int         n;
        logic [7:0] d;
        int         kind;

        rst     = 1'b0;
        rx_in   = 1'b1;
        echo_en = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_stop_err", stop_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fifo_full", fifo_full, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3 * BIT_CLKS) @(posedge clk);
        #1;

        echo_en = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        check_counts("a5");
        wait_drain("a5");

        low_before = tx_low_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        check_counts("bad_parity");
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("bad_parity_no_echo", tx_low_cnt, low_before);

        send_frame(8'h3C, 1'b0, 1'b1);
        check_counts("bad_stop");
        send_frame(8'h55, 1'b0, 1'b0);
        check_counts("after_bad_stop");
        wait_drain("after_bad_stop");

        echo_en = 1'b0;
        held    = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
            check_counts($sformatf("hold_%0d", i));
            check($sformatf("hold_%0d_fifo_full", i), fifo_full, (i >= FIFO_DEPTH) ? 1 : 0);
        end
        echo_en = 1'b1;
        held    = 0;
        wait_drain("hold_release");
        check("hold_release_fifo_full", fifo_full, 0);

        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            send_frame(d, kind == 0 || kind == 2, kind == 1 || kind == 2);
            check_counts($sformatf("rand_%0d", i));
            repeat (int'($urandom_range(0, 2)) * BIT_CLKS) @(posedge clk);
            #1;
        end
        wait_drain("rand");

        rx_in = 1'b0;
        repeat (BIT_CLKS / 4) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_counts("glitch");
        check("glitch_tx_busy", tx_busy, 0);

        echo_en = 1'b0;
        held    = 0;
        send_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        check_counts("pre_rst");
        echo_en = 1'b1;
        n = 0;
        while (tx_busy !== 1'b1 && n < 4 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_tx_busy", tx_busy, 1);
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("pre_rst_tx_low", tx_out, 0);
        mon_abort = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx_out", tx_out, 1);
        check("mid_rst_tx_busy", tx_busy, 0);
        check("mid_rst_fifo_full", fifo_full, 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        tx_low_cnt = 0;
        repeat (3 * 11 * BIT_CLKS) @(negedge clk);
        check("post_rst_fifo_empty_no_echo", tx_low_cnt, 0);
        check("post_rst_tx_busy", tx_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
